// File: rtl/cpu_load_sequencer.sv
// cpu_load_sequencer: loads a program into instruction memory, then flushes, runs, drains and halts the core.
module cpu_load_sequencer #(
    parameter int ADDR_W       = 6,
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int CYC_W        = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              LoadInstructions,
    input  logic [31:0]       Instruction,
    input  logic [31:0]       fetch_pc,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              pc_clear,
    output logic              cpu_run,
    output logic [ADDR_W:0]   prog_len,
    output logic              done,
    output logic              load_overflow,
    output logic [CYC_W-1:0]  run_cycles
);
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DRAIN, DONE} state_t;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    state_t state, state_nx;
    logic [ADDR_W:0] wr_ptr;
    logic [3:0] cnt;
    logic restart, wr, past_end, unused_ok;
    logic [ADDR_W:0] ptr;
    // any load request outside LOAD aborts whatever is in progress and restarts at address 0
    assign restart   = LoadInstructions && state != LOAD;
    assign ptr       = restart ? '0 : wr_ptr;
    assign wr        = LoadInstructions && ptr < DEPTH;
    assign past_end  = {1'b0, fetch_pc[ADDR_W+1:2]} >= prog_len || |fetch_pc[31:ADDR_W+2];
    assign unused_ok = &{1'b0, fetch_pc[1:0]};
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            cnt           <= '0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            prog_len      <= '0;
            load_overflow <= 1'b0;
            run_cycles    <= '0;
        end else begin
            state   <= state_nx;
            imem_we <= wr;
            if (wr) begin
                imem_addr  <= ptr[ADDR_W-1:0];
                imem_wdata <= Instruction;
                wr_ptr     <= ptr + 1'b1;
            end
            cnt <= state == LOAD ? 4'(FLUSH_CYCLES) : state == RUN ? 4'(DRAIN_CYCLES) : cnt - 4'(cnt != 0);
            if (state == LOAD && !LoadInstructions)
                prog_len <= wr_ptr;
            load_overflow <= restart ? 1'b0 : (state == LOAD && LoadInstructions && !wr) ? 1'b1 : load_overflow;
            run_cycles <= restart ? '0 : ((state == RUN || state == DRAIN) && ~&run_cycles) ? run_cycles + 1'b1 : run_cycles;
        end
    end
    always_comb begin
        state_nx = restart ? LOAD :
                   (state == LOAD && !LoadInstructions) ? (wr_ptr == 0 ? IDLE : FLUSH) :
                   (state == FLUSH && cnt == 4'd1) ? RUN :
                   (state == RUN && past_end) ? DRAIN :
                   (state == DRAIN && cnt == 4'd1) ? DONE : state;
    end
    always_comb begin
        pc_clear = state == IDLE || state == LOAD || state == FLUSH;
        cpu_run  = state == RUN || state == DRAIN;
        done     = state == DONE;
    end
endmodule

// File: tb/tb_cpu_load_sequencer.sv
// tb_cpu_load_sequencer: randomized run-control checks against a cycle-level behavioural model.
module tb_cpu_load_sequencer;
    localparam int AW = 3, DEPTH = 8, FL = 2, DR = 4;
    localparam int MI = 0, ML = 1, MF = 2, MR = 3, MD = 4, MX = 5;
    logic clk = 0, Reset = 1, LoadInstructions = 0;
    logic [31:0] Instruction = 0, fetch_pc = 0;
    logic imem_we, pc_clear, cpu_run, done, load_overflow;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [AW:0] prog_len;
    logic [15:0] run_cycles;
    int checks = 0, errors = 0;
    int m_mode, m_left, m_wp, m_plen, m_rc;
    bit m_ovf, e_we, wild;
    int e_addr;
    logic [31:0] e_wdata, core_pc;

    cpu_load_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .Reset(Reset), .LoadInstructions(LoadInstructions), .Instruction(Instruction),
        .fetch_pc(fetch_pc), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .pc_clear(pc_clear), .cpu_run(cpu_run), .prog_len(prog_len), .done(done),
        .load_overflow(load_overflow), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MI; m_left = 0; m_wp = 0; m_plen = 0; m_rc = 0; m_ovf = 0;
        e_we = 0; e_addr = 0; e_wdata = 0; core_pc = 0;
    endtask

    task automatic model(input bit li, input logic [31:0] ins, input logic [31:0] pc);
        bit restart;
        int ptr, was;
        restart = li && m_mode != ML;
        ptr = restart ? 0 : m_wp;
        was = m_mode;
        e_we = 0;
        if (li && ptr < DEPTH) begin
            e_we = 1; e_addr = ptr; e_wdata = ins; m_wp = ptr + 1;
        end
        if (restart) begin
            m_mode = ML; m_ovf = 0; m_rc = 0;
        end else begin
            if ((was == MR || was == MD) && m_rc < 65535) m_rc++;
            if (was == ML) begin
                if (li) begin
                    if (!e_we) m_ovf = 1;
                end else begin
                    m_plen = m_wp;
                    m_mode = m_wp == 0 ? MI : MF;
                    m_left = FL;
                end
            end else if (was == MF) begin
                m_left--;
                if (m_left == 0) m_mode = MR;
            end else if (was == MR) begin
                if ((pc >> 2) >= m_plen) begin m_mode = MD; m_left = DR; end
            end else if (was == MD) begin
                m_left--;
                if (m_left == 0) m_mode = MX;
            end
        end
    endtask

    task automatic compare_all();
        chk("pc_clear", pc_clear, m_mode <= MF);
        chk("cpu_run", cpu_run, m_mode == MR || m_mode == MD);
        chk("done", done, m_mode == MX);
        chk("imem_we", imem_we, e_we);
        chk("imem_addr", imem_addr, e_addr);
        chk("imem_wdata", imem_wdata, e_wdata);
        chk("prog_len", prog_len, m_plen);
        chk("load_overflow", load_overflow, m_ovf);
        chk("run_cycles", run_cycles, m_rc);
    endtask

    task automatic step(input bit li, input logic [31:0] ins);
        int was;
        LoadInstructions = li; Instruction = ins; fetch_pc = core_pc;
        @(posedge clk);
        was = m_mode;
        model(li, ins, core_pc);
        if (m_mode <= MF) core_pc = 0;
        else if ((was == MR || was == MD) && (m_mode == MR || m_mode == MD)) begin
            if (wild && $urandom_range(0, 9) == 0)
                core_pc = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            else core_pc = core_pc + 4;
        end
        #1 compare_all();
    endtask

    task automatic run_until_done();
        for (int n = 0; n < 200 && m_mode != MX; n++) step(0, 0);
        chk("done_timeout", done, 1);
    endtask

    task automatic run_until(input int mode);
        for (int n = 0; n < 200 && m_mode != mode; n++) step(0, 0);
        chk("reach_state", m_mode, mode);
    endtask

    initial begin
        model_reset();
        wild = 0;
        repeat (2) @(posedge clk);
        #1 compare_all();
        Reset = 0;
        repeat (3) step(0, 0);
        for (int i = 0; i < 7; i++) step(1, 32'h8C0A0064 + i);
        run_until_done();
        chk("prog_len_7", prog_len, 7);
        chk("run_cycles_12", run_cycles, 12);
        for (int i = 0; i < 10; i++) step(1, $urandom);
        run_until_done();
        chk("overflow_flag", load_overflow, 1);
        chk("prog_len_full", prog_len, 8);
        step(1, 32'h1234_5678);
        run_until_done();
        chk("prog_len_1", prog_len, 1);
        for (int i = 0; i < 5; i++) step(1, 32'hA000_0000 + i);
        run_until(MR);
        step(0, 0);
        step(0, 0);
        step(1, 32'h2001_01A7);
        chk("abort_run", cpu_run, 0);
        chk("abort_addr", imem_addr, 0);
        chk("abort_wdata", imem_wdata, 32'h2001_01A7);
        chk("abort_cycles", run_cycles, 0);
        step(1, 32'h1);
        step(1, 32'h2);
        run_until_done();
        chk("prog_len_3", prog_len, 3);
        for (int i = 0; i < 3; i++) step(1, $urandom);
        run_until(MD);
        LoadInstructions = 0;
        #2 Reset = 1;
        #1;
        chk("async_cpu_run", cpu_run, 0);
        chk("async_pc_clear", pc_clear, 1);
        chk("async_done", done, 0);
        chk("async_cycles", run_cycles, 0);
        model_reset();
        @(posedge clk);
        #1 Reset = 0;
        compare_all();
        wild = 1;
        for (int it = 0; it < 60; it++) begin
            int n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) step(1, $urandom);
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 40) == 0) step(1, $urandom);
                else step(0, 0);
            end
            if ($urandom_range(0, 9) == 0) begin
                #2 Reset = 1;
                model_reset();
                @(posedge clk);
                #1 Reset = 0;
                compare_all();
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_load_sequencer.md
Name: cpu_load_sequencer

Overview:
Run-control sequencer that sits between the bench/host load interface and the pipelined CPU core. It streams words presented on Instruction into instruction memory while LoadInstructions is high, then holds the core's PC and pipeline clear for a fixed interval. It then enables execution, detects when fetch runs past the loaded program, drains the pipeline and halts the core. It is the single owner of instruction-memory write access and of the core's run/clear controls.

Parameters:
ADDR_W, 6, instruction-memory word-address width; DEPTH = 2**ADDR_W words
FLUSH_CYCLES, 2, cycles pc_clear is held between end of load and run start (1..15)
DRAIN_CYCLES, 4, cycles cpu_run stays high after fetch passes program end (1..15)
CYC_W, 16, width of run-cycle counter

Ports:
clk  in  1  system clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
LoadInstructions  in  1  high = word on Instruction is valid this cycle and must be stored
Instruction  in  32  instruction word to store
fetch_pc  in  32  core's current fetch byte address
imem_we  out  1  instruction-memory write enable (registered)
imem_addr  out  ADDR_W  instruction-memory word address (registered)
imem_wdata  out  32  instruction-memory write data (registered)
pc_clear  out  1  forces core PC to 0 and flushes pipeline registers
cpu_run  out  1  core clock-enable; core stalls completely while low
prog_len  out  ADDR_W+1  number of words loaded in the last completed load
done  out  1  program finished and pipeline drained
load_overflow  out  1  sticky: a write was attempted with memory full
run_cycles  out  CYC_W  cycles spent in RUN+DRAIN, saturating

Behaviour:
- Reset, asynchronous: state IDLE; wr_ptr=0, prog_len=0, run_cycles=0, counters=0; imem_we=0, imem_addr=0, imem_wdata=0, pc_clear=1, cpu_run=0, done=0, load_overflow=0.
- States: IDLE, LOAD, FLUSH, RUN, DRAIN, DONE. pc_clear=1 in IDLE, LOAD and FLUSH. cpu_run=1 only in RUN and DRAIN. done=1 only in DONE.
- Write path: in any state, a cycle with LoadInstructions=1 and wr_ptr<DEPTH produces imem_we=1, imem_addr=wr_ptr, imem_wdata=Instruction on the next cycle, then wr_ptr increments. Latency is 1 cycle. imem_we is 0 in all other cycles; addr/wdata hold their last values.
- IDLE/DONE with LoadInstructions=1: wr_ptr restarts at 0. The sampled word is written to address 0, state goes to LOAD, done clears, load_overflow clears, run_cycles clears.
- LOAD with LoadInstructions=1 and wr_ptr==DEPTH: no write; load_overflow<=1; wr_ptr holds.
- LOAD with LoadInstructions=0: prog_len<=wr_ptr. If wr_ptr==0, go to IDLE; otherwise go to FLUSH and load the counter with FLUSH_CYCLES.
- FLUSH: counter decrements each cycle. When it reaches 0, the next state is RUN, so pc_clear is high for exactly FLUSH_CYCLES cycles after LOAD.
- RUN: run_cycles increments each cycle, saturating at all-ones. When fetch_pc[ADDR_W+1:2] >= prog_len, or fetch_pc[31:ADDR_W+2] != 0, go to DRAIN with counter=DRAIN_CYCLES.
- DRAIN: cpu_run stays 1 and run_cycles keeps counting. Counter decrements; at 0, go to DONE. prog_len and the memory contents are held.
- Abort: LoadInstructions=1 in FLUSH, RUN or DRAIN forces cpu_run=0 from the next cycle. The new load restarts at address 0 exactly as from IDLE. Partial run results are discarded.
- Simultaneous events: abort has priority over RUN→DRAIN and DRAIN→DONE transitions.
- Reset asserted mid-load or mid-run returns to reset values immediately. Memory contents are not touched.

Test Plan:
- Reset, then 7 load cycles of LW words (e.g. 0x8C0A0064) → imem_we pulses at addr 0..6 one cycle after each sample; prog_len=7; pc_clear high 2 cycles after LOAD; then cpu_run=1.
- After the run above, drive fetch_pc 0,4,…,24 then 28 → DRAIN entered the cycle after 28 is seen; cpu_run stays high 4 cycles; then done=1, cpu_run=0; run_cycles = RUN cycles + 4.
- With ADDR_W=3, load 10 words → writes at addr 0..7 only; load_overflow=1; prog_len=8; run still proceeds.
- LoadInstructions 1-cycle pulse then 0 → prog_len=1; then with LoadInstructions held 0 in IDLE → no writes, pc_clear stays 1, cpu_run=0.
- Assert LoadInstructions mid-RUN with word 0x2001_01A7 → cpu_run=0 next cycle; write to addr 0; run_cycles cleared; new prog_len counted from 0.
- Assert Reset during DRAIN, asynchronously between edges → cpu_run=0, pc_clear=1, done=0 immediately, without waiting for a clock edge.
